// File: rtl/strela_cg_pkg.sv
// Shared types and defaults for the STRELA fabric clock-gating controller.
package strela_cg_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_IDLE   = 2'd1,
    ST_GATED  = 2'd2,
    ST_WAKE   = 2'd3
  } cg_state_e;

  localparam int DEF_IDLE_CYCLES = 16;
  localparam int DEF_WAKE_CYCLES = 2;
  localparam int DEF_CNT_W       = 32;

  // Bits needed to hold 0..n, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/strela_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module strela_sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                      r_cnt <= '0;
    else if (i_clr)                 r_cnt <= '0;
    else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/strela_clk_gate_ctrl.sv
// Fabric clock-gate enable controller: idle-timeout gating, wake handshake
// with settle interval, and a saturating gated-cycle profile counter.
module strela_clk_gate_ctrl
  import strela_cg_pkg::*;
#(
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             gate_enable_i,
  input  logic             busy_i,
  input  logic             wake_req_i,
  output logic             wake_ack_o,
  output logic             clk_en_o,
  input  logic             gated_cnt_clr_i,
  output logic [CNT_W-1:0] gated_cnt_o,
  output logic [1:0]       state_o
);

  localparam int IW = cnt_width(IDLE_CYCLES);
  localparam int WW = cnt_width(WAKE_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

  cg_state_e     r_state;
  logic [IW-1:0] r_idle_cnt;
  logic [WW-1:0] r_wake_cnt;
  logic          r_clk_en;
  logic          r_ack;
  logic          w_act;

  assign w_act = busy_i | wake_req_i | ~gate_enable_i;

  // Outputs are loaded alongside the state they belong to, so they always
  // reflect the registered state with no input-to-output path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_ACTIVE;
      r_clk_en   <= 1'b1;
      r_ack      <= 1'b1;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (!w_act) begin
            r_state    <= ST_IDLE;
            r_idle_cnt <= '0;
          end
        end
        ST_IDLE: begin
          if (w_act) begin
            r_state <= ST_ACTIVE;
          end else if (r_idle_cnt == IDLE_LAST) begin
            r_state  <= ST_GATED;
            r_clk_en <= 1'b0;
            r_ack    <= 1'b0;
          end else begin
            r_idle_cnt <= r_idle_cnt + IW'(1);
          end
        end
        ST_GATED: begin
          // busy while gated is handled like a wake request
          if (w_act) begin
            r_clk_en <= 1'b1;
            if (WAKE_CYCLES == 0) begin
              r_state <= ST_ACTIVE;
              r_ack   <= 1'b1;
            end else begin
              r_state    <= ST_WAKE;
              r_wake_cnt <= '0;
            end
          end
        end
        ST_WAKE: begin
          if (r_wake_cnt == WAKE_LAST) begin
            r_state <= ST_ACTIVE;
            r_ack   <= 1'b1;
          end else begin
            r_wake_cnt <= r_wake_cnt + WW'(1);
          end
        end
        default: begin
          r_state  <= ST_ACTIVE;
          r_clk_en <= 1'b1;
          r_ack    <= 1'b1;
        end
      endcase
    end
  end

  strela_sat_counter #(.W(CNT_W)) u_gated_cnt (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_inc (r_state == ST_GATED),
    .i_clr (gated_cnt_clr_i),
    .o_cnt (gated_cnt_o)
  );

  assign clk_en_o   = r_clk_en;
  assign wake_ack_o = r_ack;
  assign state_o    = r_state;

endmodule

// File: doc/strela_clk_gate_ctrl.md
Name: strela_clk_gate_ctrl

Overview:
- Clock-gating controller for the STRELA CGRA fabric.
- Runs on the free-running (ungated) clock and drives the enable input of the fabric clock-gate cell.
- Gates the fabric clock after a programmable number of consecutive idle cycles.
- Re-enables the clock on a wake request and acknowledges once the clock has run for a settle interval; also keeps a saturating gated-cycle counter for power profiling.

Parameters:
- IDLE_CYCLES, 16, consecutive idle cycles in IDLE before gating; legal range ≥1.
- WAKE_CYCLES, 2, clocked settle cycles after re-enable before wake_ack_o; legal range ≥0.
- CNT_W, 32, width of the gated-cycle counter.

Ports:
- clk_i  in  1  free-running clock (ungated).
- rst_i  in  1  asynchronous reset, active-high.
- gate_enable_i  in  1  software enable of auto-gating; 0 forces the clock on.
- busy_i  in  1  fabric activity (execution or memory transactions in flight).
- wake_req_i  in  1  level request for a running fabric clock; held until wake_ack_o is seen.
- wake_ack_o  out  1  fabric clock is running and stable.
- clk_en_o  out  1  to clock-gate en_i (test enable is wired directly to the gate, not through this block).
- gated_cnt_clr_i  in  1  synchronous clear of gated_cnt_o.
- gated_cnt_o  out  CNT_W  saturating count of cycles spent in GATED.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state ACTIVE, clk_en_o=1, wake_ack_o=1.
  - idle and wake counters = 0, gated_cnt_o = 0.
- All outputs are registered and derived from the next state. No combinational path from any input to any output.
- Define `activity = busy_i | wake_req_i | ~gate_enable_i`.
- ACTIVE (state_o=0, clk_en_o=1, ack=1):
  - If ~activity → IDLE with idle_cnt=0.
  - Otherwise stay.
- IDLE (state_o=1, clk_en_o=1, ack=1):
  - If activity → ACTIVE.
  - Else if idle_cnt==IDLE_CYCLES-1 → GATED.
  - Else idle_cnt++.
- GATED (state_o=2, clk_en_o=0, ack=0):
  - If activity → WAKE with wake_cnt=0. busy_i while gated is treated defensively as a wake.
  - If WAKE_CYCLES==0, go directly → ACTIVE instead.
- WAKE (state_o=3, clk_en_o=1, ack=0):
  - If wake_cnt==WAKE_CYCLES-1 → ACTIVE; else wake_cnt++.
  - Input changes are ignored until the settle interval completes. A wake_req_i drop during WAKE still finishes in ACTIVE.
- Timing:
  - Gating: from a quiet ACTIVE state, clk_en_o falls IDLE_CYCLES+1 rising edges after activity drops.
  - Wake: activity sampled in GATED at edge t gives clk_en_o=1 after edge t and wake_ack_o=1 after edge t+WAKE_CYCLES.
- Gated-cycle counter:
  - gated_cnt increments on every edge where the current state is GATED.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - gated_cnt_clr_i has priority over increment: clear and increment in the same cycle give 0.
- Boundary cases:
  - Activity in the same cycle IDLE would reach its terminal count: return to ACTIVE, do not gate.
  - gate_enable_i low at any point: the block ends in ACTIVE within WAKE_CYCLES+1 edges and stays there.
  - Reset mid-operation (any state): clock is re-enabled immediately.
- Counter widths:
  - Idle counter width is $clog2(IDLE_CYCLES+1).
  - Wake counter width is $clog2(WAKE_CYCLES+1), minimum 1.

Decomposition:
- Package strela_cg_pkg holds:
  - the state enum typedef (ACTIVE=0, IDLE=1, GATED=2, WAKE=3);
  - default constants for IDLE_CYCLES, WAKE_CYCLES and CNT_W.
- One sub-module: strela_sat_counter (parameter width; increment, clear; clear has priority; saturates at max). Used for gated_cnt_o.
- The FSM and the idle/wake counters stay in the top module.

Test Plan:
1. Reset release with gate_enable_i=1, busy_i=0, wake_req_i=0 (IDLE_CYCLES=16) → clk_en_o stays 1 for 17 edges, 0 from edge 17; state_o sequence 0,1,…,1,2; wake_ack_o falls together with clk_en_o.
2. busy_i pulsed for one cycle when idle_cnt=10 → state returns to ACTIVE and no gating occurs; gating then happens 17 edges after busy_i drops.
3. In GATED, raise and hold wake_req_i (WAKE_CYCLES=2) → clk_en_o=1 after the next edge, wake_ack_o=1 two edges later, state_o 2→3→0; repeat with WAKE_CYCLES=0 → clk_en_o and wake_ack_o both rise after the same edge.
4. In GATED, drop gate_enable_i → block wakes and stays ACTIVE for 200 quiet cycles with clk_en_o=1; re-raising gate_enable_i regates after 17 edges.
5. Gate for 100 cycles → gated_cnt_o=100; assert gated_cnt_clr_i during a gated cycle → 0 next cycle. With CNT_W=4, gate for 40 cycles → gated_cnt_o holds at 15.
6. Assert rst_i asynchronously mid-cycle while GATED → clk_en_o=1 and wake_ack_o=1 before the next clk_i edge, gated_cnt_o=0, state_o=0.
